// File: rtl/fpu_sequencer.sv
// rtl/fpu_sequencer.sv - issue/latency/response sequencer wrapped around a fixed-latency FPU
module fpu_sequencer #(
  parameter int LAT_CVT    = 6,
  parameter int LAT_ADDSUB = 7,
  parameter int LAT_MUL    = 5,
  parameter int LAT_DIV    = 6,
  parameter int LAT_SQRT   = 16,
  parameter int LAT_NEG    = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_in1,
  input  logic [31:0] req_in2,
  input  logic [2:0]  req_func,
  output logic [31:0] fpu_in1,
  output logic [31:0] fpu_in2,
  output logic [2:0]  fpu_func,
  input  logic [31:0] fpu_out,
  input  logic        fpu_overflow,
  input  logic        fpu_underflow,
  input  logic        fpu_nan,
  input  logic        fpu_divzero,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic [3:0]  rsp_flags,
  output logic        busy,
  output logic [3:0]  status,
  input  logic        clr_status
);

  localparam logic [2:0] F_CVTIS = 3'd0;
  localparam logic [2:0] F_CVTSI = 3'd1;
  localparam logic [2:0] F_SQRT  = 3'd2;
  localparam logic [2:0] F_NEG   = 3'd3;
  localparam logic [2:0] F_ADD   = 3'd4;
  localparam logic [2:0] F_SUB   = 3'd5;
  localparam logic [2:0] F_MUL   = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] fpu_in1_q, fpu_in1_d;
  logic [31:0] fpu_in2_q, fpu_in2_d;
  logic [2:0]  fpu_func_q, fpu_func_d;
  logic [31:0] rsp_result_q, rsp_result_d;
  logic [3:0]  rsp_flags_q, rsp_flags_d;
  logic [3:0]  status_q, status_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        busy_q, busy_d;
  logic        req_ready_q, req_ready_d;
  logic        capture;
  logic [3:0]  cap_flags;

  // Counter preload is latency minus one: the capture happens on the edge where it reads zero.
  function automatic logic [4:0] lat_m1(input logic [2:0] f);
    case (f)
      F_CVTIS, F_CVTSI: lat_m1 = 5'(LAT_CVT - 1);
      F_SQRT:           lat_m1 = 5'(LAT_SQRT - 1);
      F_NEG:            lat_m1 = 5'(LAT_NEG - 1);
      F_ADD, F_SUB:     lat_m1 = 5'(LAT_ADDSUB - 1);
      F_MUL:            lat_m1 = 5'(LAT_MUL - 1);
      default:          lat_m1 = 5'(LAT_DIV - 1);
    endcase
  endfunction

  // Each operation only reports the exceptions it can actually raise; the rest read as zero.
  function automatic logic [3:0] flag_mask(input logic [2:0] f);
    case (f)
      F_CVTIS, F_CVTSI, F_NEG: flag_mask = 4'b0000;
      F_SQRT:                  flag_mask = 4'b0010;
      F_ADD, F_SUB, F_MUL:     flag_mask = 4'b0111;
      default:                 flag_mask = 4'b1111;
    endcase
  endfunction

  // Next-state logic: accept in IDLE, count down in BUSY, hold the response in DONE.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    fpu_in1_d    = fpu_in1_q;
    fpu_in2_d    = fpu_in2_q;
    fpu_func_d   = fpu_func_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    capture      = 1'b0;
    cap_flags    = {fpu_divzero, fpu_nan, fpu_overflow, fpu_underflow} & flag_mask(fpu_func_q);

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          fpu_in1_d  = req_in1;
          fpu_in2_d  = req_in2;
          fpu_func_d = req_func;
          cnt_d      = lat_m1(req_func);
          state_d    = S_BUSY;
        end
      end
      S_BUSY: begin
        if (cnt_q == 5'd0) begin
          capture      = 1'b1;
          rsp_result_d = fpu_out;
          rsp_flags_d  = cap_flags;
          state_d      = S_DONE;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      S_DONE: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A clear on a capture edge leaves exactly the fresh flags behind.
    if (clr_status) begin
      status_d = capture ? cap_flags : 4'b0000;
    end else begin
      status_d = status_q | (capture ? cap_flags : 4'b0000);
    end

    rsp_valid_d = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
    req_ready_d = (state_d == S_IDLE);
  end

  // State and registered outputs; reset drops any in-flight operation.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= S_IDLE;
      cnt_q        <= 5'd0;
      fpu_in1_q    <= 32'd0;
      fpu_in2_q    <= 32'd0;
      fpu_func_q   <= 3'd0;
      rsp_result_q <= 32'd0;
      rsp_flags_q  <= 4'd0;
      status_q     <= 4'd0;
      rsp_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      req_ready_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      fpu_in1_q    <= fpu_in1_d;
      fpu_in2_q    <= fpu_in2_d;
      fpu_func_q   <= fpu_func_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
      status_q     <= status_d;
      rsp_valid_q  <= rsp_valid_d;
      busy_q       <= busy_d;
      req_ready_q  <= req_ready_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign fpu_in1    = fpu_in1_q;
  assign fpu_in2    = fpu_in2_q;
  assign fpu_func   = fpu_func_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;
  assign busy       = busy_q;
  assign status     = status_q;

endmodule

// File: tb/tb_fpu_sequencer.sv
// tb/tb_fpu_sequencer.sv - self-checking bench for fpu_sequencer
module tb_fpu_sequencer;

  localparam int L_CVT = 6, L_ADDSUB = 7, L_MUL = 5, L_DIV = 6, L_SQRT = 16, L_NEG = 1;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_in1 = 32'd0;
  logic [31:0] req_in2 = 32'd0;
  logic [2:0]  req_func = 3'd0;
  logic [31:0] fpu_in1, fpu_in2;
  logic [2:0]  fpu_func;
  logic [31:0] fpu_out = 32'd0;
  logic        fpu_overflow = 1'b0, fpu_underflow = 1'b0, fpu_nan = 1'b0, fpu_divzero = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_flags;
  logic        busy;
  logic [3:0]  status;
  logic        clr_status = 1'b0;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  logic [31:0] rsp_log[$];

  fpu_sequencer #(
    .LAT_CVT(L_CVT), .LAT_ADDSUB(L_ADDSUB), .LAT_MUL(L_MUL),
    .LAT_DIV(L_DIV), .LAT_SQRT(L_SQRT), .LAT_NEG(L_NEG)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_in1(req_in1), .req_in2(req_in2), .req_func(req_func),
    .fpu_in1(fpu_in1), .fpu_in2(fpu_in2), .fpu_func(fpu_func),
    .fpu_out(fpu_out), .fpu_overflow(fpu_overflow), .fpu_underflow(fpu_underflow),
    .fpu_nan(fpu_nan), .fpu_divzero(fpu_divzero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags),
    .busy(busy), .status(status), .clr_status(clr_status)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
  endtask

  function automatic int lat_of(input logic [2:0] f);
    case (f)
      3'd0, 3'd1: return L_CVT;
      3'd2:       return L_SQRT;
      3'd3:       return L_NEG;
      3'd4, 3'd5: return L_ADDSUB;
      3'd6:       return L_MUL;
      default:    return L_DIV;
    endcase
  endfunction

  // Reported flags {divzero,nan,overflow,underflow} by operation class.
  function automatic logic [3:0] keep_flags(input logic [2:0] f, input logic [3:0] raw);
    case (f)
      3'd2:             return raw & 4'b0010;
      3'd4, 3'd5, 3'd6: return raw & 4'b0111;
      3'd7:             return raw;
      default:          return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] mix(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] h;
    h = (a ^ {b[15:0], b[31:16]}) * 32'h9E3779B1;
    return h + {29'd0, f};
  endfunction

  // Stand-in FPU: a few real IEEE results for the directed cases, a hash otherwise.
  function automatic logic [31:0] fpu_calc(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f == 3'd3) return a ^ 32'h8000_0000;
    if (f == 3'd4 && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
    if (f == 3'd6 && a == 32'h3F800000 && b == 32'h40000000) return 32'h40000000;
    if (f == 3'd2 && a == 32'h41800000) return 32'h40800000;
    if (f == 3'd7 && b == 32'd0) return 32'h7F800000;
    if (f == 3'd4 && a == 32'h7F7FFFFF && b == 32'h7F7FFFFF) return 32'h7F800000;
    return mix(f, a, b);
  endfunction

  function automatic logic [3:0] fpu_raw_flags(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] h;
    if (f == 3'd4 && a == 32'h3F800000 && b == 32'h40000000) return 4'b0000;
    if (f == 3'd6 && a == 32'h3F800000 && b == 32'h40000000) return 4'b0000;
    if (f == 3'd2 && a == 32'h41800000) return 4'b0000;
    if (f == 3'd7 && b == 32'd0) return 4'b1000;
    if (f == 3'd4 && a == 32'h7F7FFFFF && b == 32'h7F7FFFFF) return 4'b0010;
    h = mix(f, a, b);
    return h[31:28] ^ h[7:4];
  endfunction

  // Reference: an operation accepted on edge N completes on edge N+LAT and waits for rsp_ready.
  bit          m_busy = 0, m_valid = 0;
  int          m_done_at = 0;
  logic [31:0] m_in1 = 0, m_in2 = 0, m_result = 0;
  logic [2:0]  m_func = 0;
  logic [3:0]  m_flags = 0, m_status = 0;

  always @(negedge clk_i) begin
    logic [3:0] raw;
    logic [3:0] kept;
    bit         cap;
    if (!rst_i) begin
      m_busy = 0; m_valid = 0; m_in1 = 0; m_in2 = 0; m_func = 0;
      m_result = 0; m_flags = 0; m_status = 0;
    end
    check("req_ready", {31'd0, req_ready}, {31'd0, !m_busy});
    check("busy", {31'd0, busy}, {31'd0, m_busy});
    check("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_valid});
    check("rsp_result", rsp_result, m_result);
    check("rsp_flags", {28'd0, rsp_flags}, {28'd0, m_flags});
    check("status", {28'd0, status}, {28'd0, m_status});
    check("fpu_in1", fpu_in1, m_in1);
    check("fpu_in2", fpu_in2, m_in2);
    check("fpu_func", {29'd0, fpu_func}, {29'd0, m_func});
    if (rst_i && rsp_valid && rsp_ready) rsp_log.push_back(rsp_result);

    cap = rst_i && m_busy && !m_valid && (cyc + 1 == m_done_at);
    raw = fpu_raw_flags(m_func, m_in1, m_in2);
    kept = keep_flags(m_func, raw);
    if (cap) begin
      fpu_out = fpu_calc(m_func, m_in1, m_in2);
      {fpu_divzero, fpu_nan, fpu_overflow, fpu_underflow} = raw;
    end else begin
      fpu_out = $urandom;
      {fpu_divzero, fpu_nan, fpu_overflow, fpu_underflow} = 4'($urandom);
    end
    if (rst_i) begin
      if (clr_status) m_status = cap ? kept : 4'b0000;
      else if (cap) m_status = m_status | kept;
      if (m_valid) begin
        if (rsp_ready) begin m_valid = 0; m_busy = 0; end
      end else if (m_busy) begin
        if (cap) begin
          m_valid = 1;
          m_result = fpu_calc(m_func, m_in1, m_in2);
          m_flags = kept;
        end
      end else if (req_valid) begin
        m_busy = 1;
        m_in1 = req_in1; m_in2 = req_in2; m_func = req_func;
        m_done_at = cyc + 1 + lat_of(req_func);
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, output int acc);
    int n;
    n = 0;
    while (!req_ready && n < 200) begin tick(); n++; end
    if (n >= 200) fail_now("issue_ready");
    req_valid = 1'b1; req_func = f; req_in1 = a; req_in2 = b;
    tick();
    acc = cyc;
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int at);
    int n;
    n = 0;
    while (!rsp_valid && n < 200) begin tick(); n++; end
    if (n >= 200) fail_now("wait_rsp");
    at = cyc;
  endtask

  task automatic ack();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    int acc, at, acc2;
    tick();
    tick();
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset_status", {28'd0, status}, 32'd0);
    rst_i = 1'b1;
    tick();
    check("reset_req_ready", {31'd0, req_ready}, 32'd1);

    // ADD 1.0 + 2.0
    issue(3'd4, 32'h3F800000, 32'h40000000, acc);
    wait_rsp(at);
    check("add_latency", at - acc, 32'd7);
    check("add_result", rsp_result, 32'h40400000);
    check("add_flags", {28'd0, rsp_flags}, 32'd0);
    ack();

    // DIV by zero, then a clean MUL, then clear
    issue(3'd7, 32'h3F800000, 32'h00000000, acc);
    wait_rsp(at);
    check("div_latency", at - acc, 32'd6);
    check("div_divzero", {31'd0, rsp_flags[3]}, 32'd1);
    ack();
    check("div_status", {28'd0, status}, 32'h8);
    issue(3'd6, 32'h3F800000, 32'h40000000, acc);
    wait_rsp(at);
    check("mul_latency", at - acc, 32'd5);
    check("mul_result", rsp_result, 32'h40000000);
    ack();
    check("mul_status_sticky", {28'd0, status}, 32'h8);
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    check("clr_status", {28'd0, status}, 32'd0);

    // SQRT 16.0 held under backpressure while new requests are offered
    issue(3'd2, 32'h41800000, 32'h0, acc);
    wait_rsp(at);
    check("sqrt_latency", at - acc, 32'd16);
    for (int i = 0; i < 10; i++) begin
      req_valid = i[0];
      req_func = 3'($urandom);
      req_in1 = $urandom;
      tick();
      check("bp_valid", {31'd0, rsp_valid}, 32'd1);
      check("bp_result", rsp_result, 32'h40800000);
      check("bp_fpu_in1", fpu_in1, 32'h41800000);
    end
    req_valid = 1'b0;
    ack();

    // Reset five cycles into a SQRT
    issue(3'd2, 32'h41800000, 32'h0, acc);
    repeat (5) tick();
    rst_i = 1'b0;
    #1;
    check("async_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("async_busy", {31'd0, busy}, 32'd0);
    check("async_fpu_in1", fpu_in1, 32'd0);
    check("async_req_ready", {31'd0, req_ready}, 32'd1);
    tick();
    tick();
    rst_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("post_reset_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    issue(3'd4, 32'h3F800000, 32'h40000000, acc);
    wait_rsp(at);
    check("post_reset_add_lat", at - acc, 32'd7);
    check("post_reset_add", rsp_result, 32'h40400000);
    ack();

    // NEG back-to-back with rsp_ready tied high
    rsp_log.delete();
    rsp_ready = 1'b1;
    issue(3'd3, 32'h3F800000, 32'h0, acc);
    issue(3'd3, 32'hBF800000, 32'h0, acc2);
    repeat (4) tick();
    rsp_ready = 1'b0;
    check("neg_interval", acc2 - acc, 32'd3);
    check("neg_count", rsp_log.size(), 32'd2);
    if (rsp_log.size() >= 2) begin
      check("neg_first", rsp_log[0], 32'hBF800000);
      check("neg_second", rsp_log[1], 32'h3F800000);
    end

    // Clear coinciding with a DIV-by-zero capture, after an overflowing ADD
    issue(3'd4, 32'h7F7FFFFF, 32'h7F7FFFFF, acc);
    wait_rsp(at);
    ack();
    check("ovf_status", {28'd0, status}, 32'h2);
    issue(3'd7, 32'h3F800000, 32'h0, acc);
    repeat (L_DIV - 1) tick();
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    check("clr_cap_valid", {31'd0, rsp_valid}, 32'd1);
    check("clr_cap_status", {28'd0, status}, 32'h8);
    ack();

    // Randomized traffic checked every cycle by the reference
    for (int i = 0; i < 4000; i++) begin
      req_valid = ($urandom % 3) != 0;
      req_func = 3'($urandom);
      req_in1 = ($urandom % 8 == 0) ? 32'h3F800000 : $urandom;
      req_in2 = ($urandom % 8 == 0) ? 32'h0 : $urandom;
      rsp_ready = ($urandom % 4) != 0;
      clr_status = ($urandom % 16) == 0;
      rst_i = ($urandom % 700) != 0;
      tick();
    end
    rst_i = 1'b1;
    req_valid = 1'b0;
    clr_status = 1'b0;
    rsp_ready = 1'b1;
    repeat (40) tick();
    check("drained", {31'd0, busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
